// File: rtl/dcp_tx_arbiter.sv
// dcp_tx_arbiter: message-level round-robin arbiter sharing one UART
// transmit byte channel among N_REQ print units, with idle-owner watchdog.
module dcp_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_rdy,
    output logic [N_REQ-1:0]   grant,
    input  logic               rdy_tx,
    output logic               vld_tx,
    output logic [7:0]         d_tx,
    output logic               timeout_err
);

    localparam int PW = $clog2(N_REQ);
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner_idx;
    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [TO_W-1:0] wd;
    logic [7:0]      owner_data;
    logic [N_REQ-1:0] take;
    logic            free;
    logic            accept;
    logic            acc_last;
    logic            owner_vld;
    logic            idle_tick;
    logic            wd_fire;

    assign free      = ~vld_tx | rdy_tx;
    assign req_rdy   = grant & {N_REQ{free}};
    assign take      = req_vld & req_rdy;
    assign accept    = |take;
    assign acc_last  = |(take & req_last);
    assign owner_vld = |(req_vld & grant);
    // Stalls caused by a full buffer must not look like a hung owner.
    assign idle_tick = ~owner_vld & free;
    assign wd_fire   = WD_EN & idle_tick & (wd == TO_LAST);
    assign next_ptr  = (owner_idx == PW'(N_REQ - 1)) ?
                       '0 : owner_idx + PW'(1);

    // Decode the one-hot grant into an index and select the owner's byte.
    always_comb begin
        owner_idx  = '0;
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner_idx  = PW'(i);
                owner_data = req_data[i*8 +: 8];
            end
        end
    end

    // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int            j;
            logic [PW-1:0] cand;
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = PW'(j);
            if (!pick_found && req_vld[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Ownership FSM with round-robin pointer and idle-owner watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    wd <= '0;
                    if (pick_found) begin
                        grant <= ONE << pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (acc_last) begin
                        grant  <= '0;
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                        wd     <= '0;
                    end else if (wd_fire) begin
                        grant       <= '0;
                        state       <= IDLE;
                        rr_ptr      <= next_ptr;
                        wd          <= '0;
                        timeout_err <= 1'b1;
                    end else if (accept) begin
                        wd <= '0;
                    end else if (WD_EN && idle_tick) begin
                        wd <= wd + TO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // One-byte output buffer: load on owner accept, empty on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_tx <= 1'b0;
            d_tx   <= 8'h00;
        end else if (accept) begin
            vld_tx <= 1'b1;
            d_tx   <= owner_data;
        end else if (rdy_tx) begin
            vld_tx <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcp_tx_arbiter.sv
// tb_dcp_tx_arbiter: directed checks of dcp_tx_arbiter using two
// instances (TIMEOUT=4 for the main flow, TIMEOUT=8 for the watchdog).
module tb_dcp_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic [3:0]  req_vld = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_rdy;
    logic [3:0]  grant;
    logic        rdy_tx = 1'b1;
    logic        vld_tx;
    logic [7:0]  d_tx;
    logic        timeout_err;

    logic [3:0]  b_req_vld = '0;
    logic [3:0]  b_req_last = '0;
    logic [31:0] b_req_data = '0;
    logic [3:0]  b_req_rdy;
    logic [3:0]  b_grant;
    logic        b_rdy_tx = 1'b1;
    logic        b_vld_tx;
    logic [7:0]  b_d_tx;
    logic        b_timeout_err;

    dcp_tx_arbiter #(.N_REQ(4), .TIMEOUT(4), .TO_W(3)) u_dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_last(req_last), .req_data(req_data),
        .req_rdy(req_rdy), .grant(grant),
        .rdy_tx(rdy_tx), .vld_tx(vld_tx), .d_tx(d_tx),
        .timeout_err(timeout_err)
    );

    dcp_tx_arbiter #(.N_REQ(4), .TIMEOUT(8), .TO_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .req_vld(b_req_vld), .req_last(b_req_last), .req_data(b_req_data),
        .req_rdy(b_req_rdy), .grant(b_grant),
        .rdy_tx(b_rdy_tx), .vld_tx(b_vld_tx), .d_tx(b_d_tx),
        .timeout_err(b_timeout_err)
    );

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [7:0] d);
        req_vld[i] = v;
        req_last[i] = l;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req_vld = 4'hF;
        b_req_vld = 4'hF;
        repeat (3) step();
        checks++;
        if ({grant, req_rdy, vld_tx, d_tx, timeout_err} !== 18'h0) begin
            errors++;
            $display("FAIL reset_a: got %h want %h",
                {grant, req_rdy, vld_tx, d_tx, timeout_err}, 18'h0);
        end
        checks++;
        if ({b_grant, b_req_rdy, b_vld_tx, b_d_tx, b_timeout_err} !== 18'h0) begin
            errors++;
            $display("FAIL reset_b: got %h want %h",
                {b_grant, b_req_rdy, b_vld_tx, b_d_tx, b_timeout_err}, 18'h0);
        end
        req_vld = '0;
        b_req_vld = '0;
        rst = 1'b1;
    endtask

    task automatic test_single;
        set_req(0, 1, 0, 8'h41);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_t: got %b want %b", grant, 4'b0000);
        end
        step();
        checks++;
        if ({grant, req_rdy, vld_tx, d_tx} !== {4'b0001, 4'b0001, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL single_t1: got %h want %h",
                {grant, req_rdy, vld_tx, d_tx}, {4'b0001, 4'b0001, 1'b0, 8'h00});
        end
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0001, 1'b1, 8'h41}) begin
            errors++;
            $display("FAIL single_b41: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0001, 1'b1, 8'h41});
        end
        set_req(0, 1, 0, 8'h42);
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0001, 1'b1, 8'h42}) begin
            errors++;
            $display("FAIL single_b42: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0001, 1'b1, 8'h42});
        end
        set_req(0, 1, 1, 8'h43);
        step();
        checks++;
        if ({grant, req_rdy, vld_tx, d_tx} !== {4'b0000, 4'b0000, 1'b1, 8'h43}) begin
            errors++;
            $display("FAIL single_b43: got %h want %h",
                {grant, req_rdy, vld_tx, d_tx}, {4'b0000, 4'b0000, 1'b1, 8'h43});
        end
        set_req(0, 0, 0, 8'h00);
        step();
        checks++;
        if ({grant, vld_tx} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL single_drain: got %h want %h",
                {grant, vld_tx}, {4'b0000, 1'b0});
        end
    endtask

    task automatic test_round_robin;
        set_req(1, 1, 0, 8'hA1);
        set_req(2, 1, 0, 8'hB1);
        step();
        checks++;
        if ({grant, req_rdy, vld_tx} !== {4'b0010, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL rr_g1: got %h want %h",
                {grant, req_rdy, vld_tx}, {4'b0010, 4'b0010, 1'b0});
        end
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0010, 1'b1, 8'hA1}) begin
            errors++;
            $display("FAIL rr_a1: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0010, 1'b1, 8'hA1});
        end
        set_req(1, 1, 1, 8'hA2);
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0000, 1'b1, 8'hA2}) begin
            errors++;
            $display("FAIL rr_a2: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0000, 1'b1, 8'hA2});
        end
        set_req(1, 0, 0, 8'h00);
        step();
        checks++;
        if ({grant, req_rdy, vld_tx} !== {4'b0100, 4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL rr_g2: got %h want %h",
                {grant, req_rdy, vld_tx}, {4'b0100, 4'b0100, 1'b0});
        end
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0100, 1'b1, 8'hB1}) begin
            errors++;
            $display("FAIL rr_b1: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0100, 1'b1, 8'hB1});
        end
        set_req(2, 1, 1, 8'hB2);
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0000, 1'b1, 8'hB2}) begin
            errors++;
            $display("FAIL rr_b2: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0000, 1'b1, 8'hB2});
        end
        set_req(2, 0, 0, 8'h00);
        set_req(0, 1, 1, 8'hC0);
        set_req(3, 1, 1, 8'hD3);
        step();
        checks++;
        if ({grant, req_rdy} !== {4'b1000, 4'b1000}) begin
            errors++;
            $display("FAIL rr_scan3: got %h want %h",
                {grant, req_rdy}, {4'b1000, 4'b1000});
        end
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0000, 1'b1, 8'hD3}) begin
            errors++;
            $display("FAIL rr_d3: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0000, 1'b1, 8'hD3});
        end
        set_req(3, 0, 0, 8'h00);
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap: got %b want %b", grant, 4'b0001);
        end
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0000, 1'b1, 8'hC0}) begin
            errors++;
            $display("FAIL rr_c0: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0000, 1'b1, 8'hC0});
        end
        set_req(0, 0, 0, 8'h00);
        step();
    endtask

    task automatic test_backpressure;
        set_req(1, 1, 0, 8'hE0);
        step();
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0010, 1'b1, 8'hE0}) begin
            errors++;
            $display("FAIL bp_e0: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0010, 1'b1, 8'hE0});
        end
        rdy_tx = 1'b0;
        set_req(1, 0, 0, 8'hE1);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({grant, req_rdy, vld_tx, d_tx, timeout_err} !==
                {4'b0010, 4'b0000, 1'b1, 8'hE0, 1'b0}) begin
                errors++;
                $display("FAIL bp_stall%0d: got %h want %h", i,
                    {grant, req_rdy, vld_tx, d_tx, timeout_err},
                    {4'b0010, 4'b0000, 1'b1, 8'hE0, 1'b0});
            end
        end
        rdy_tx = 1'b1;
        set_req(1, 1, 0, 8'hE1);
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0010, 1'b1, 8'hE1}) begin
            errors++;
            $display("FAIL bp_e1: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0010, 1'b1, 8'hE1});
        end
        set_req(1, 1, 1, 8'hE2);
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0000, 1'b1, 8'hE2}) begin
            errors++;
            $display("FAIL bp_e2: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0000, 1'b1, 8'hE2});
        end
        set_req(1, 0, 0, 8'h00);
        step();
    endtask

    task automatic test_timeout;
        b_req_vld = 4'b1000;
        b_req_last = 4'b0000;
        b_req_data[31:24] = 8'h5A;
        step();
        step();
        checks++;
        if ({b_grant, b_vld_tx, b_d_tx} !== {4'b1000, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL to_5a: got %h want %h",
                {b_grant, b_vld_tx, b_d_tx}, {4'b1000, 1'b1, 8'h5A});
        end
        b_req_vld = 4'b0001;
        b_req_last = 4'b0001;
        b_req_data[7:0] = 8'h77;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if ({b_grant, b_req_rdy, b_vld_tx, b_timeout_err} !==
                {4'b1000, 4'b1000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL to_hold%0d: got %h want %h", i,
                    {b_grant, b_req_rdy, b_vld_tx, b_timeout_err},
                    {4'b1000, 4'b1000, 1'b0, 1'b0});
            end
        end
        step();
        checks++;
        if ({b_grant, b_timeout_err} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL to_fire: got %h want %h",
                {b_grant, b_timeout_err}, {4'b0000, 1'b1});
        end
        step();
        checks++;
        if ({b_grant, b_timeout_err} !== {4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL to_next: got %h want %h",
                {b_grant, b_timeout_err}, {4'b0001, 1'b0});
        end
        step();
        checks++;
        if ({b_grant, b_vld_tx, b_d_tx} !== {4'b0000, 1'b1, 8'h77}) begin
            errors++;
            $display("FAIL to_77: got %h want %h",
                {b_grant, b_vld_tx, b_d_tx}, {4'b0000, 1'b1, 8'h77});
        end
        b_req_vld = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid;
        set_req(2, 1, 0, 8'h99);
        step();
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0100, 1'b1, 8'h99}) begin
            errors++;
            $display("FAIL rm_99: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0100, 1'b1, 8'h99});
        end
        rdy_tx = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({grant, req_rdy, vld_tx, d_tx, timeout_err} !== 18'h0) begin
            errors++;
            $display("FAIL rm_async: got %h want %h",
                {grant, req_rdy, vld_tx, d_tx, timeout_err}, 18'h0);
        end
        set_req(2, 0, 0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        rdy_tx = 1'b1;
        set_req(1, 1, 1, 8'hF1);
        set_req(3, 1, 1, 8'hF3);
        step();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL rm_ptr: got %b want %b", grant, 4'b0010);
        end
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0000, 1'b1, 8'hF1}) begin
            errors++;
            $display("FAIL rm_f1: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0000, 1'b1, 8'hF1});
        end
        set_req(1, 0, 0, 8'h00);
        step();
        step();
        checks++;
        if ({grant, vld_tx, d_tx} !== {4'b0000, 1'b1, 8'hF3}) begin
            errors++;
            $display("FAIL rm_f3: got %h want %h",
                {grant, vld_tx, d_tx}, {4'b0000, 1'b1, 8'hF3});
        end
        set_req(3, 0, 0, 8'h00);
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
